key_debounce_n: RTL
===================

// Module: key_debounce_n
// PURPOSE
//  N-channel push-button conditioner; successor to the fixed two-key (key1/key2) input path of mips_top.
//  Synchronises, debounces and edge-detects each key. Latches press events into pending bits and raises
//  one maskable irq toward the CPU. Sits between board pins and the mips_top peripheral bus.
// PARAMETERS
//  NKEYS      2      number of key channels (1..16)
//  CNT_W      16     width of per-channel debounce counter
//  DEBOUNCE   50000  consecutive stable cycles required to accept a level change (2..2^CNT_W-1)
//  ACT_HIGH   1      1: key_in high = pressed; 0: key_in low = pressed
//  LONG_CNT   0x7FFFF cycles held (after accept) for long-press event; only with KEY_LONGPRESS_EN
// PORTS
//  clk         in   1      system clock
//  rst         in   1      asynchronous active-low reset
//  key_in      in   NKEYS  raw asynchronous key pins
//  irq_mask    in   NKEYS  1 = channel may raise irq
//  pend_clr    in   NKEYS  1-cycle pulse per bit: clear pending bit
//  key_state   out  NKEYS  debounced level, 1 = pressed (polarity normalised)
//  key_press   out  NKEYS  1-cycle pulse on accepted press
//  key_release out  NKEYS  1-cycle pulse on accepted release
//  key_pend    out  NKEYS  sticky pending press flags
//  key_long    out  NKEYS  1-cycle long-press pulse (0 when feature compiled out)
//  irq         out  1      registered OR of (key_pend & irq_mask)
// BEHAVIOUR
//  - Reset (rst=0, async): sync flops load inactive level; counters 0; FSMs IDLE; all outputs 0.
//  - Input: 2-flop synchroniser per channel, then polarity normalised (p = ACT_HIGH ? s : ~s).
//  - Per-channel FSM: IDLE -> PCHK when p=1; PCHK: cnt++ while p=1, p=0 -> IDLE (cnt=0);
//    cnt==DEBOUNCE-1 with p=1 -> PRESSED, cnt=0, key_state<=1, key_press pulse.
//    PRESSED -> RCHK when p=0; RCHK: cnt++ while p=0, p=1 -> PRESSED (cnt=0);
//    cnt==DEBOUNCE-1 with p=0 -> IDLE, cnt=0, key_state<=0, key_release pulse.
//  - Latency: pin edge -> key_state/pulse = 2 + DEBOUNCE clock edges; any glitch shorter than
//    DEBOUNCE synchronised cycles produces no event and leaves key_state unchanged.
//  - key_press/key_release/key_long registered, high exactly one cycle, same edge as key_state change.
//  - key_pend[i] set by key_press[i]; cleared by pend_clr[i]; press and clear same cycle -> stays set.
//  - irq registered: one cycle after key_pend/irq_mask change. Masking does not clear pend.
//  - Counter saturates: never wraps; only compared for equality with DEBOUNCE-1.
//  - Channels fully independent; simultaneous events on several channels all reported same cycle.
//  - Reset mid-count: event discarded, channel returns to IDLE; no pulse emitted on reset exit.
//  - Key held across reset release: reported as a new press 2+DEBOUNCE cycles after rst rises.
// CONFIGURATION
//  KEY_LONGPRESS_EN defined: in PRESSED a second per-channel counter (width for LONG_CNT) counts
//    held cycles; at LONG_CNT emits one key_long pulse, then holds (one pulse per press);
//    counter cleared on entering PRESSED from PCHK, retained across RCHK bounce back to PRESSED.
//  Not defined: no long counter synthesised; key_long tied to 0.
// TESTING (bench uses DEBOUNCE=4, NKEYS=2, ACT_HIGH=1, LONG_CNT=20)
//  1 rst low 2 cycles then high, key_in=00 -> all outputs 0 for 50 cycles, irq=0.
//  2 key_in[0] 0->1 held -> key_state[0]=1 and key_press[0]=1 for 1 cycle 6 edges later;
//    key_pend[0]=1; irq=1 next cycle with irq_mask=01; irq stays 0 with irq_mask=00.
//  3 key_in[0] high 3 cycles then low (glitch) -> no key_press, key_state[0] stays 0.
//  4 pend_clr[0] pulse coincident with new key_press[0] -> key_pend[0] remains 1;
//    pend_clr[0] alone -> key_pend[0]=0 next cycle, irq=0 one cycle later.
//  5 both keys rise same cycle -> key_press=11 same cycle; release both -> key_release=11 after 6 edges.
//  6 KEY_LONGPRESS_EN: hold key_in[1] 40 cycles -> one key_long[1] pulse 20 cycles after key_press[1];
//    rst driven low mid-debounce -> outputs 0 immediately, no pulse after rst release unless still held.

Source files
------------

// File: rtl/key_debounce_n_if.sv
// Key conditioner bus: pins and CPU-side controls in, debounced status out.
// master = board/CPU side, slave = key_debounce_n.
interface key_debounce_n_if #(
  parameter int NKEYS = 2
);
  logic [NKEYS-1:0] key_in;
  logic [NKEYS-1:0] irq_mask;
  logic [NKEYS-1:0] pend_clr;
  logic [NKEYS-1:0] key_state;
  logic [NKEYS-1:0] key_press;
  logic [NKEYS-1:0] key_release;
  logic [NKEYS-1:0] key_pend;
  logic [NKEYS-1:0] key_long;
  logic             irq;

  modport master (
    output key_in,
    output irq_mask,
    output pend_clr,
    input  key_state,
    input  key_press,
    input  key_release,
    input  key_pend,
    input  key_long,
    input  irq
  );

  modport slave (
    input  key_in,
    input  irq_mask,
    input  pend_clr,
    output key_state,
    output key_press,
    output key_release,
    output key_pend,
    output key_long,
    output irq
  );
endinterface

// File: rtl/key_debounce_n.sv
// N-channel key synchroniser/debouncer with pending flags and one irq.
// Define KEY_LONGPRESS_EN to build the per-channel long-press detector.
module key_debounce_n #(
  parameter int NKEYS    = 2,
  parameter int CNT_W    = 16,
  parameter int DEBOUNCE = 50000,
  parameter int ACT_HIGH = 1,
  parameter int LONG_CNT = 'h7FFFF
) (
  input logic             clk,
  input logic             rst,
  key_debounce_n_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE,
    PCHK,
    PRESSED,
    RCHK
  } st_e;

  localparam logic [CNT_W-1:0] DB_LAST =
    CNT_W'(DEBOUNCE - 1);
  localparam logic [CNT_W-1:0] CNT_ONE =
    CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic INACT =
    (ACT_HIGH != 0) ? 1'b0 : 1'b1;

`ifdef KEY_LONGPRESS_EN
  localparam int LW = $clog2(LONG_CNT + 1);
  localparam logic [LW-1:0] L_LAST =
    LW'(LONG_CNT - 1);
  localparam logic [LW-1:0] L_MAX =
    LW'(LONG_CNT);
`endif

  if (NKEYS < 1 || NKEYS > 16 ||
      DEBOUNCE < 2 ||
      (DEBOUNCE >> CNT_W) != 0 ||
      LONG_CNT < 1) begin : g_bad_cfg
    $error("key_debounce_n: bad parameters");
  end

  logic [NKEYS-1:0] state_v;
  logic [NKEYS-1:0] press_v;
  logic [NKEYS-1:0] rel_v;
  logic [NKEYS-1:0] long_v;
  logic [NKEYS-1:0] pend_q;
  logic             irq_q;

  for (genvar i = 0; i < NKEYS; i++) begin : g_ch
    logic             s1;
    logic             s2;
    logic             p;
    st_e              st_q;
    st_e              st_d;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic             press;
    logic             rel;
    logic             state_q;
    logic             press_q;
    logic             rel_q;
    logic             long_q;

    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        s1 <= INACT;
        s2 <= INACT;
      end else begin
        s1 <= bus.key_in[i];
        s2 <= s1;
      end
    end

    assign p = (ACT_HIGH != 0) ? s2 : ~s2;

    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        st_q  <= IDLE;
        cnt_q <= '0;
      end else begin
        st_q  <= st_d;
        cnt_q <= cnt_d;
      end
    end

    // Entering a check state counts the first
    // stable sample, so DEBOUNCE samples accept.
    always_comb begin
      st_d  = st_q;
      cnt_d = cnt_q;
      press = 1'b0;
      rel   = 1'b0;
      unique case (st_q)
        IDLE: begin
          if (p) begin
            st_d  = PCHK;
            cnt_d = CNT_ONE;
          end
        end
        PCHK: begin
          if (!p) begin
            st_d  = IDLE;
            cnt_d = '0;
          end else if (cnt_q == DB_LAST) begin
            st_d  = PRESSED;
            cnt_d = '0;
            press = 1'b1;
          end else if (cnt_q != CNT_MAX) begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        PRESSED: begin
          if (!p) begin
            st_d  = RCHK;
            cnt_d = CNT_ONE;
          end
        end
        RCHK: begin
          if (p) begin
            st_d  = PRESSED;
            cnt_d = '0;
          end else if (cnt_q == DB_LAST) begin
            st_d  = IDLE;
            cnt_d = '0;
            rel   = 1'b1;
          end else if (cnt_q != CNT_MAX) begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        default: begin
          st_d  = IDLE;
          cnt_d = '0;
        end
      endcase
    end

    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        state_q <= 1'b0;
        press_q <= 1'b0;
        rel_q   <= 1'b0;
      end else begin
        press_q <= press;
        rel_q   <= rel;
        if (press) begin
          state_q <= 1'b1;
        end else if (rel) begin
          state_q <= 1'b0;
        end
      end
    end

`ifdef KEY_LONGPRESS_EN
    logic [LW-1:0] lcnt_q;
    logic [LW-1:0] lcnt_d;
    logic          long_d;

    // Saturating at LONG_CNT gives one pulse per
    // press; RCHK bounces keep the count.
    always_comb begin
      lcnt_d = lcnt_q;
      long_d = 1'b0;
      if (press) begin
        lcnt_d = '0;
      end else if (st_q == PRESSED &&
                   lcnt_q != L_MAX) begin
        lcnt_d = lcnt_q + 1'b1;
        long_d = (lcnt_q == L_LAST);
      end
    end

    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        lcnt_q <= '0;
        long_q <= 1'b0;
      end else begin
        lcnt_q <= lcnt_d;
        long_q <= long_d;
      end
    end
`else
    assign long_q = 1'b0;
`endif

    assign state_v[i] = state_q;
    assign press_v[i] = press_q;
    assign rel_v[i]   = rel_q;
    assign long_v[i]  = long_q;
  end

  // Pend follows the registered press pulse, so a
  // clear seen while key_press is high loses.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pend_q <= '0;
      irq_q  <= 1'b0;
    end else begin
      pend_q <= (pend_q & ~bus.pend_clr) | press_v;
      irq_q  <= |(pend_q & bus.irq_mask);
    end
  end

  assign bus.key_state   = state_v;
  assign bus.key_press   = press_v;
  assign bus.key_release = rel_v;
  assign bus.key_long    = long_v;
  assign bus.key_pend    = pend_q;
  assign bus.irq         = irq_q;

endmodule
